// File: rtl/mprj_status_arbiter_if.sv
// Requester-side bundle of the status arbiter: per-requester valid/data in,
// one-hot ready strobe out.
interface mprj_status_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/mprj_status_arbiter.sv
// Round-robin arbiter for the mprj_io[31:16] status field. Every granted word
// stays on the pads for at least HOLD_CYCLES cycles.
module mprj_status_arbiter #(
    parameter int                 NUM_REQ     = 4,
    parameter int                 DATA_W      = 16,
    parameter int                 HOLD_CYCLES = 8,
    parameter logic [DATA_W-1:0]  IDLE_VALUE  = '0
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic                       enable,
    mprj_status_arbiter_if.slave       req,
    output logic [DATA_W-1:0]          status_out,
    output logic [DATA_W-1:0]          status_oeb,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [7:0]                 word_count
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  hold_cnt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              grant;
    logic [DATA_W-1:0] win_data;

    // Round-robin pick: scanning offsets from high to low makes the nearest
    // valid index after last_grant the one that sticks.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch is inferred on any path.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (req.req_valid[ID_W'(idx)]) begin
                winner    = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == winner) win_data = req.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Gated by resetb so no strobe leaks out while reset is held.
    assign grant = resetb && (state == IDLE) && enable && any_valid;

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant)           state_next = HOLD;
            HOLD:    if (hold_cnt == '0)  state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        req.req_ready = '0;
        busy          = 1'b0;
        case (state)
            IDLE:    if (grant) req.req_ready = NUM_REQ'(1) << winner;
            HOLD:    busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            status_out <= IDLE_VALUE;
            grant_id   <= '0;
            last_grant <= LAST_INIT;
            word_count <= '0;
            hold_cnt   <= '0;
        end else if (grant) begin
            status_out <= win_data;
            grant_id   <= winner;
            last_grant <= winner;
            word_count <= word_count + 8'd1;
            hold_cnt   <= HOLD_LOAD;
        end else if (state == HOLD && hold_cnt != '0) begin
            hold_cnt   <= hold_cnt - 1'b1;
        end
    end

    // Pad enable follows 'enable' one cycle late; pads float out of reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) status_oeb <= '1;
        else         status_oeb <= {DATA_W{~enable}};
    end
endmodule

// File: tb/tb_mprj_status_arbiter.sv
// Scoreboard bench for mprj_status_arbiter: tests queue expected grants, a
// monitor pops them on each req_ready and follows the hold window.
module tb_mprj_status_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int HOLD    = 8;

    typedef struct {
        int              id;
        logic [DATA_W-1:0] data;
    } grant_t;

    logic clock = 1'b0;
    logic resetb = 1'b0;
    logic enable = 1'b0;
    logic [DATA_W-1:0] status_out, status_oeb;
    logic busy;
    logic [1:0] grant_id;
    logic [7:0] word_count;

    mprj_status_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) req_if ();

    mprj_status_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .IDLE_VALUE(16'h0000)
    ) dut (
        .clock(clock), .resetb(resetb), .enable(enable), .req(req_if),
        .status_out(status_out), .status_oeb(status_oeb), .busy(busy),
        .grant_id(grant_id), .word_count(word_count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int grants_seen = 0;
    int grant_times[$];
    grant_t exp_q[$];
    logic [DATA_W-1:0] src_q[NUM_REQ][$];

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester model: each requester offers the head of its queue and
    // retires it after the edge on which valid&ready was seen.
    initial begin
        logic [NUM_REQ-1:0] acc;
        req_if.req_valid = '0;
        req_if.req_data  = '0;
        forever begin
            @(negedge clock);
            acc = resetb ? (req_if.req_ready & req_if.req_valid) : '0;
            @(posedge clock);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                req_if.req_valid[i] = (src_q[i].size() != 0);
                req_if.req_data[i*DATA_W +: DATA_W] =
                    (src_q[i].size() != 0) ? src_q[i][0] : '0;
            end
        end
    end

    // Monitor: pops an expectation on each ready strobe, then checks the
    // HOLD cycles that follow and the return to idle.
    initial begin
        int     hold_left = 0;
        logic   post_hold = 1'b0;
        grant_t cur;
        cur.id = 0;
        cur.data = '0;
        forever begin
            @(negedge clock);
            if (!resetb) begin
                hold_left = 0;
                post_hold = 1'b0;
            end else if (hold_left > 0) begin
                check("hold_busy", 32'(busy), 1);
                check("hold_status", 32'(status_out), 32'(cur.data));
                check("hold_grant_id", 32'(grant_id), 32'(cur.id));
                check("hold_ready", 32'(req_if.req_ready), 0);
                hold_left--;
                post_hold = (hold_left == 0);
            end else begin
                if (post_hold) begin
                    check("post_hold_busy", 32'(busy), 0);
                    check("post_hold_status", 32'(status_out), 32'(cur.data));
                    post_hold = 1'b0;
                end
                if (req_if.req_ready != '0) begin
                    grants_seen++;
                    grant_times.push_back(cycle);
                    if (exp_q.size() == 0) begin
                        check("unexpected_ready", 32'(req_if.req_ready), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("ready_onehot", 32'(req_if.req_ready), 32'(1) << cur.id);
                        hold_left = HOLD;
                    end
                end
            end
        end
    end

    task automatic expect_grant(input int id, input logic [DATA_W-1:0] data);
        grant_t g;
        g.id = id;
        g.data = data;
        exp_q.push_back(g);
    endtask

    task automatic offer(input int id, input logic [DATA_W-1:0] data);
        src_q[id].push_back(data);
    endtask

    task automatic wait_exp_size(input int n, input string name);
        int budget = 300;
        while (exp_q.size() > n && budget > 0) begin
            @(negedge clock);
            #2;
            budget--;
        end
        check({name, "_timeout"}, 32'(exp_q.size() > n), 0);
    endtask

    task automatic drain(input string name);
        wait_exp_size(0, name);
        repeat (HOLD + 2) @(negedge clock);
        #2;
    endtask

    initial begin
        int base;
        // Reset state
        #23;
        @(negedge clock);
        check("rst_status", 32'(status_out), 32'h0000);
        check("rst_oeb", 32'(status_oeb), 32'hFFFF);
        check("rst_ready", 32'(req_if.req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_word_count", 32'(word_count), 0);
        @(posedge clock); #2 resetb = 1'b1;
        @(posedge clock); #2 enable = 1'b1;
        @(negedge clock);
        check("oeb_lag_before", 32'(status_oeb), 32'hFFFF);
        @(negedge clock);
        check("oeb_enabled", 32'(status_oeb), 32'h0000);

        // Single request from requester 2
        #1;
        expect_grant(2, 16'hAB60);
        offer(2, 16'hAB60);
        drain("single");
        check("single_word_count", 32'(word_count), 1);
        check("single_oeb", 32'(status_oeb), 32'h0000);

        // Two words from requester 0, back to back
        base = grant_times.size();
        expect_grant(0, 16'hAB60);
        expect_grant(0, 16'hAB61);
        offer(0, 16'hAB60);
        offer(0, 16'hAB61);
        drain("sequence");
        repeat (5) @(negedge clock);
        check("seq_gap", 32'(grant_times[base+1] - grant_times[base]), HOLD + 1);
        check("seq_status_kept", 32'(status_out), 32'hAB61);
        check("seq_word_count", 32'(word_count), 3);

        // All four valid straight out of reset
        @(posedge clock); #2 resetb = 1'b0;
        @(posedge clock); #2 resetb = 1'b1;
        @(negedge clock); #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            expect_grant(i, 16'h1000 + 16'(i));
            offer(i, 16'h1000 + 16'(i));
        end
        expect_grant(0, 16'h1004);
        offer(0, 16'h1004);
        drain("all_four");
        check("all_four_word_count", 32'(word_count), 5);

        // Round robin: after 2, valids on 1 and 3 -> 3 then 1
        expect_grant(2, 16'hC002);
        expect_grant(3, 16'hC003);
        expect_grant(1, 16'hC001);
        offer(2, 16'hC002);
        wait_exp_size(2, "rr_first");
        offer(1, 16'hC001);
        offer(3, 16'hC003);
        drain("rr");
        check("rr_word_count", 32'(word_count), 8);

        // enable dropped mid-hold with a request still pending
        expect_grant(0, 16'hE000);
        expect_grant(1, 16'hE001);
        offer(0, 16'hE000);
        offer(1, 16'hE001);
        wait_exp_size(1, "en_first");
        @(posedge clock); #2 enable = 1'b0;
        @(negedge clock);
        check("en_oeb_lag", 32'(status_oeb), 32'h0000);
        @(negedge clock);
        check("en_oeb_off", 32'(status_oeb), 32'hFFFF);
        base = grants_seen;
        repeat (20) @(negedge clock);
        check("en_no_grant", 32'(grants_seen - base), 0);
        check("en_hold_done", 32'(busy), 0);
        check("en_status_kept", 32'(status_out), 32'hE000);
        @(posedge clock); #2 enable = 1'b1;
        drain("en_resume");
        check("en_word_count", 32'(word_count), 10);

        // Async reset in the middle of a hold
        expect_grant(1, 16'hD001);
        offer(1, 16'hD001);
        wait_exp_size(0, "rst_first");
        offer(0, 16'hD100);
        offer(2, 16'hD102);
        repeat (2) @(negedge clock);
        @(posedge clock); #3 resetb = 1'b0;
        #1;
        check("mid_rst_status", 32'(status_out), 32'h0000);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_word_count", 32'(word_count), 0);
        check("mid_rst_ready", 32'(req_if.req_ready), 0);
        check("mid_rst_oeb", 32'(status_oeb), 32'hFFFF);
        expect_grant(0, 16'hD100);
        expect_grant(2, 16'hD102);
        repeat (3) @(negedge clock);
        @(posedge clock); #3 resetb = 1'b1;
        drain("after_rst");
        check("after_rst_word_count", 32'(word_count), 2);
        check("after_rst_grant_id", 32'(grant_id), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mprj_status_arbiter.md
# mprj_status_arbiter

Shares the 16-bit user-project status field (mprj_io[31:16]) between several on-chip requesters (firmware via logic analyzer, user-logic self-test sequencers, etc.). Grants one requester at a time, round-robin, and holds each granted word stable on the pads for a guaranteed minimum number of cycles so that external monitors waiting on exact values (e.g. 16'hAB60 then 16'hAB61) never miss a checkpoint. Sits in the user project area between the requesters and the mprj_io output/oeb pins.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, status word width
- HOLD_CYCLES, 8, minimum cycles each granted word stays on status_out (>=1)
- IDLE_VALUE, 16'h0000, status_out value after reset

Ports:
- clock  input  1  single clock, all logic on rising edge
- resetb  input  1  asynchronous, active-low reset
- enable  input  1  1 = arbitration allowed and pads driven
- req_valid  input  NUM_REQ  per-requester word available
- req_data  input  NUM_REQ*DATA_W  requester i word in bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot accept strobe; word taken on the edge where valid&ready
- status_out  output  DATA_W  word driven to mprj_io[31:16]
- status_oeb  output  DATA_W  pad output-enable, active-low, all bits identical
- busy  output  1  1 while in HOLD
- grant_id  output  clog2(NUM_REQ)  index of requester owning status_out
- word_count  output  8  number of accepted words, wraps 255->0

## Operation

- FSM states: IDLE, HOLD.
- IDLE: if enable=1 and any req_valid, choose winner = first valid index searching upward from (last_grant+1) mod NUM_REQ; req_ready[winner]=1 combinationally for that cycle only; on the edge: status_out<=req_data[winner], grant_id<=winner, last_grant<=winner, word_count+=1, hold counter<=HOLD_CYCLES-1, state->HOLD.
- IDLE with enable=0 or no valid: req_ready=0, state stays IDLE, outputs unchanged.
- HOLD: req_ready=0; counter decrements each cycle; at counter==0 state->IDLE on next edge.
- status_out retains last granted word indefinitely after HOLD; it never reverts to IDLE_VALUE except by reset.
- enable falling during HOLD: current hold completes normally; no new grant until enable=1.
- status_oeb <= {DATA_W{~enable}} registered (one-cycle lag).
- Requester deasserting req_valid while not granted: simply not considered; no ready is ever issued to a non-valid requester.
- req_data of a non-granted requester is ignored.

## Timing

- Reset (async assert, sync-free release): state=IDLE, status_out=IDLE_VALUE, status_oeb=all 1, req_ready=0, busy=0, grant_id=0, word_count=0, last_grant=NUM_REQ-1 (so requester 0 has first priority).
- Grant latency: req_valid asserted at cycle N in IDLE with enable=1 -> req_ready same cycle N -> status_out new value at N+1.
- status_out stable for exactly HOLD_CYCLES cycles (N+1..N+HOLD_CYCLES) with busy=1; IDLE at N+HOLD_CYCLES+1, earliest next ready that cycle.
- Max throughput: one word per HOLD_CYCLES+1 cycles.
- HOLD_CYCLES=1: busy for one cycle, period 2.
- Reset mid-HOLD: all state cleared immediately; pending requesters re-arbitrated from index 0 after release.
- Simultaneous valids: strictly round-robin; no requester starves while it keeps req_valid high (wait <= NUM_REQ grants).

## Test plan

- Single request: req_valid[2]=1, data 16'hAB60, enable=1 -> req_ready[2] pulses 1 cycle, status_out=16'hAB60 next cycle, grant_id=2, busy 8 cycles, word_count=1, status_oeb=16'h0000.
- Sequence: requester 0 sends 16'hAB60 then 16'hAB61 -> each visible exactly 8 cycles min, grants 9 cycles apart, status_out holds 16'hAB61 afterward.
- All four valid from reset -> grant order 0,1,2,3,0; each req_ready one-hot, single-cycle.
- Round-robin: after grant to 2, valids on 1 and 3 -> 3 granted, then 1.
- enable dropped mid-HOLD with requests pending -> hold finishes, no req_ready while enable=0, status_oeb=16'hFFFF one cycle after drop; re-enable -> grants resume.
- resetb low mid-HOLD (async, off-edge) -> status_out=16'h0000, busy=0, word_count=0 immediately; after release requester 0 wins first.
